// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped, read-only instruction cache.
// Hits return the addressed 32-bit word combinationally. A miss fetches the
// whole 128-bit block from instruction memory and installs it before retrying.
// Optional build macro ICACHE_PERF_EN adds saturating hit/miss counters
// (hit_count, miss_count). Without it those ports and counters do not exist.
module icache_direct_mapped #(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = $clog2(NUM_SETS),
    parameter int TAG_W    = 28 - INDEX_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [31:0]  address,
    input  logic         flush,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [27:0]  mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state_reg;
    logic   flush_pending_reg;
    logic   mem_read_reg;
    logic [27:0] mem_address_reg;

    // Line storage; tags and data are never reset, only the valid bits are.
    logic           valid_reg [NUM_SETS];
    logic [TAG_W-1:0] tag_mem [NUM_SETS];
    logic [127:0]   data_mem [NUM_SETS];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         word_sel;
    logic               hit;
    logic               invalidate_all;
    logic               install;
    logic               unused_addr_bits;

    assign index    = address[4 +: INDEX_W];
    assign tag      = address[31 -: TAG_W];
    assign word_sel = address[3:2];
    // Byte offset within the word is meaningless for instruction fetch.
    assign unused_addr_bits = &{1'b0, address[1:0]};

    assign hit = valid_reg[index] && (tag_mem[index] == tag);

    // A pending or fresh flush is only honoured in IDLE so a fill in flight is never cut short.
    assign invalidate_all = (state_reg == IDLE) && (flush || flush_pending_reg);
    assign install        = (state_reg == UPDATE);

    assign busywait    = read && ((state_reg != IDLE) || !hit || flush_pending_reg);
    assign mem_read    = mem_read_reg;
    assign mem_address = mem_address_reg;

    // Word select out of the indexed line; zero unless the lookup hits.
    always_comb begin
        instruction = 32'd0;
        if (hit) begin
            case (word_sel)
                2'd0:    instruction = data_mem[index][31:0];
                2'd1:    instruction = data_mem[index][63:32];
                2'd2:    instruction = data_mem[index][95:64];
                default: instruction = data_mem[index][127:96];
            endcase
        end
    end

    // Per-set valid bits: cleared by reset or flush, set when the line is installed.
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_reg[gi] <= 1'b0;
            end else if (invalidate_all) begin
                valid_reg[gi] <= 1'b0;
            end else if (install && (index == INDEX_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    // Tag and data write on the UPDATE edge; address is held stable by the CPU during a fill.
    always_ff @(posedge clock) begin
        if (install) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= mem_readdata;
        end
    end

    // Miss-handling FSM with registered memory request outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            flush_pending_reg <= 1'b0;
            mem_read_reg      <= 1'b0;
            mem_address_reg   <= 28'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush || flush_pending_reg) begin
                        flush_pending_reg <= 1'b0;
                    end else if (read && !hit) begin
                        state_reg       <= MEM_READ;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= address[31:4];
                    end
                end
                MEM_READ: begin
                    if (flush) begin
                        flush_pending_reg <= 1'b1;
                    end
                    if (!mem_busywait) begin
                        state_reg    <= UPDATE;
                        mem_read_reg <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (flush) begin
                        flush_pending_reg <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_read_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    // Saturating counters; a flush does not clear them.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else begin
            if ((state_reg == IDLE) && read && hit && !flush_pending_reg
                    && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if ((state_reg == IDLE) && !invalidate_all && read && !hit
                    && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Testbench for icache_direct_mapped: directed fetches followed by random ones,
// checked against a set/block-address model of a direct-mapped cache with
// a 16-beat instruction memory behind it.
module tb_icache_direct_mapped;

    logic         clock = 1'b0;
    logic         reset;
    logic         read;
    logic [31:0]  address;
    logic         flush;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    icache_direct_mapped dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .flush        (flush),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clock = ~clock;

    // Instruction memory contents as a function of block address and word.
    function automatic logic [31:0] line_word(input logic [27:0] blk, input logic [1:0] w);
        logic [31:0] b;
        b = {4'h0, blk};
        if (blk == 28'd0) begin
            case (w)
                2'd0:    return 32'hC180_0013;
                2'd1:    return 32'h0020_8093;
                2'd2:    return 32'h1234_5678;
                default: return 32'h9ABC_DEF0;
            endcase
        end
        if (blk == 28'd1 && w == 2'd2) return 32'h0000_207F;
        if (blk == 28'd1 && w == 2'd3) return 32'h0000_A2A3;
        return (b * 32'h9E37_79B1) + ({30'd0, w} * 32'h0100_0193) + 32'h5A5A_0001;
    endfunction

    // 16-beat memory: busy until the 16th cycle of a held request.
    logic [3:0] beat;
    always @(posedge clock) begin
        if (!mem_read) beat <= 4'd0;
        else           beat <= beat + 4'd1;
    end
    assign mem_busywait = !(mem_read && beat == 4'd15);
    always_comb begin
        mem_readdata = '0;
        for (int w = 0; w < 4; w++) begin
            mem_readdata[32*w +: 32] = line_word(mem_address, 2'(w));
        end
    end

    // Reference model: which block address each of the 8 sets holds.
    logic        m_valid [8];
    logic [27:0] m_blk   [8];
    int exp_hits;
    int exp_misses;
    int passes;
    int checks;

    task automatic model_clear();
        for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One CPU fetch held until busywait drops; flush_at>0 pulses flush on that cycle of a miss.
    task automatic fetch(input logic [31:0] addr, input int flush_at, input string tag);
        logic [27:0] blk;
        int          set;
        bit          exp_hit;
        int          fa;
        int          exp_busy;
        int          exp_mr;
        int          cyc;
        int          mr;
        logic [27:0] first_ma;
        bit          seen;
        blk      = addr[31:4];
        set      = int'(blk % 28'd8);
        exp_hit  = m_valid[set] && (m_blk[set] == blk);
        fa       = exp_hit ? 0 : flush_at;
        exp_busy = exp_hit ? 0 : ((fa > 0) ? 37 : 18);
        exp_mr   = exp_hit ? 0 : ((fa > 0) ? 32 : 16);
        cyc      = 0;
        mr       = 0;
        first_ma = 28'd0;
        seen     = 1'b0;
        @(negedge clock);
        read    = 1'b1;
        address = addr;
        flush   = 1'b0;
        #1;
        while (busywait && cyc < 200) begin
            if (mem_read) begin
                mr++;
                if (!seen) begin
                    seen     = 1'b1;
                    first_ma = mem_address;
                end
            end
            cyc++;
            @(negedge clock);
            flush = (cyc == fa);
            #1;
        end
        flush = 1'b0;
        check({tag, " busy_cycles"}, cyc, exp_busy);
        check({tag, " mem_read_beats"}, mr, exp_mr);
        check({tag, " instruction"}, instruction, line_word(blk, addr[3:2]));
        check({tag, " mem_read_after"}, {31'd0, mem_read}, 32'd0);
        if (!exp_hit) begin
            check({tag, " mem_address"}, {4'h0, first_ma}, {4'h0, blk});
            if (fa > 0) begin
                model_clear();
                exp_misses += 2;
            end else begin
                exp_misses += 1;
            end
            m_valid[set] = 1'b1;
            m_blk[set]   = blk;
        end
        exp_hits++;
        $display("fetch %s addr=%h hit=%0d busy=%0d instr=%h", tag, addr, exp_hit, cyc, instruction);
    endtask

    task automatic idle_flush(input string tag);
        @(negedge clock);
        read  = 1'b0;
        flush = 1'b1;
        #1;
        check({tag, " busywait"}, {31'd0, busywait}, 32'd0);
        check({tag, " mem_read"}, {31'd0, mem_read}, 32'd0);
        @(negedge clock);
        flush = 1'b0;
        model_clear();
        $display("flush %s", tag);
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_EN
        check({tag, " hit_count"}, hit_count, 32'(exp_hits));
        check({tag, " miss_count"}, miss_count, 32'(exp_misses));
`else
        $display("counters %s not built", tag);
`endif
    endtask

    initial begin
        logic [27:0] rblk;
        logic [31:0] raddr;
        int          rfa;
        passes     = 0;
        checks     = 0;
        exp_hits   = 0;
        exp_misses = 0;
        model_clear();
        for (int s = 0; s < 8; s++) m_blk[s] = 28'd0;

        // Reset with a pending request: nothing issued, request seen as a miss.
        reset   = 1'b1;
        read    = 1'b1;
        address = 32'h0;
        flush   = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset mem_read", {31'd0, mem_read}, 32'd0);
        check("reset mem_address", {4'h0, mem_address}, 32'd0);
        check("reset busywait", {31'd0, busywait}, 32'd1);
        check("reset instruction", instruction, 32'd0);
        check_counters("reset");
        @(negedge clock);
        reset = 1'b0;
        read  = 1'b0;

        fetch(32'h0000_0000, 0, "t1_miss");
        fetch(32'h0000_0004, 0, "t2_hit");
        check_counters("after_t2");
        fetch(32'h0000_0018, 0, "t3_a");
        fetch(32'h0000_001C, 0, "t3_b");
        fetch(32'h0000_0080, 0, "t4_conflict");
        fetch(32'h0000_0000, 0, "t4_remiss");
        fetch(32'h0000_0040, 5, "t5_flush_fill");
        fetch(32'h0000_0044, 0, "t5_hit");
        idle_flush("idle");
        fetch(32'h0000_0004, 0, "after_flush");
        check_counters("before_reset");

        // Reset in the middle of a fill.
        @(negedge clock);
        read    = 1'b1;
        address = 32'h0000_0200;
        repeat (6) @(negedge clock);
        #1;
        check("midfill mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("midreset mem_read", {31'd0, mem_read}, 32'd0);
        check("midreset mem_address", {4'h0, mem_address}, 32'd0);
        check("midreset busywait", {31'd0, busywait}, 32'd1);
        reset = 1'b0;
        read  = 1'b0;
        model_clear();
        exp_hits   = 0;
        exp_misses = 0;
        check_counters("midreset");
        fetch(32'h0000_0004, 0, "post_reset_a");
        fetch(32'h0000_0018, 0, "post_reset_b");

        // Random fetches over 32 blocks (conflicting in 8 sets) plus some far tags.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle_flush("rand");
            end else begin
                rblk = 28'($urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) rblk = rblk | 28'hABC_0000;
                raddr = {rblk, 4'($urandom_range(0, 15))};
                rfa   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 17)) : 0;
                fetch(raddr, rfa, "rand");
            end
        end
        check_counters("final");

        @(negedge clock);
        read = 1'b0;
        #1;
        check("idle busywait", {31'd0, busywait}, 32'd0);
        check("idle mem_read", {31'd0, mem_read}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
